// File: rtl/gpio_irq_filter_if.sv
// Signal bundle between the GPIO CSR block and gpio_irq_filter.
// Optional level-mode select is present only when GPIO_IRQ_LEVEL_EN is defined.
interface gpio_irq_filter_if #(
  parameter int N_GPIO = 32,
  parameter int DIV_W  = 16
);
  logic [N_GPIO-1:0] gpio_in_sync;
  logic              cfg_filter_en;
  logic [DIV_W-1:0]  cfg_div;
  logic [N_GPIO-1:0] cfg_rise_en;
  logic [N_GPIO-1:0] cfg_fall_en;
  logic [N_GPIO-1:0] cfg_irq_en;
  logic [N_GPIO-1:0] status_clr;
`ifdef GPIO_IRQ_LEVEL_EN
  logic [N_GPIO-1:0] cfg_level;
`endif
  logic [N_GPIO-1:0] gpio_filt;
  logic [N_GPIO-1:0] irq_status;
  logic              irq;

  // No handshake: config is level-sampled every cycle, status_clr is a
  // one-cycle write-1-to-clear pulse, outputs are registered levels.
  modport master (
    output gpio_in_sync, cfg_filter_en, cfg_div, cfg_rise_en, cfg_fall_en,
           cfg_irq_en, status_clr,
`ifdef GPIO_IRQ_LEVEL_EN
    output cfg_level,
`endif
    input  gpio_filt, irq_status, irq
  );

  modport slave (
    input  gpio_in_sync, cfg_filter_en, cfg_div, cfg_rise_en, cfg_fall_en,
           cfg_irq_en, status_clr,
`ifdef GPIO_IRQ_LEVEL_EN
    input  cfg_level,
`endif
    output gpio_filt, irq_status, irq
  );
endinterface

// File: rtl/gpio_irq_filter.sv
// Per-pin prescaled glitch filter, edge detection and sticky W1C interrupt status.
// Define GPIO_IRQ_LEVEL_EN to add per-pin level-sensitive status via cfg_level.
module gpio_irq_filter #(
  parameter int N_GPIO     = 32,
  parameter int DIV_W      = 16,
  parameter int FILT_DEPTH = 3
) (
  input logic               sys_clk,
  input logic               rst,
  gpio_irq_filter_if.slave  bus
);
  localparam int FW = $clog2(FILT_DEPTH + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(FILT_DEPTH);

  logic [DIV_W-1:0]      cnt;
  logic                  tick;
  logic [FW-1:0]         fill;
  logic [FILT_DEPTH-1:0] hist [N_GPIO];
  logic [N_GPIO-1:0]     valid;
  logic [N_GPIO-1:0]     qual;
  logic [N_GPIO-1:0]     cand;
  logic [N_GPIO-1:0]     rise;
  logic [N_GPIO-1:0]     fall;
  logic [N_GPIO-1:0]     set;
  logic [N_GPIO-1:0]     filt_q;
  logic [N_GPIO-1:0]     stat_q;
  logic                  irq_q;

  // >= compare so lowering cfg_div below the running count ticks at once.
  assign tick = (cnt >= bus.cfg_div);

  // History is only trusted once FILT_DEPTH real samples have been taken
  // since reset; otherwise the cleared all-zero history would qualify.
  always_comb begin
    qual = '0;
    cand = '0;
    for (int i = 0; i < N_GPIO; i++) begin
      if (bus.cfg_filter_en) begin
        qual[i] = (fill == FILL_MAX) && ((&hist[i]) || !(|hist[i]));
        cand[i] = hist[i][0];
      end else begin
        qual[i] = 1'b1;
        cand[i] = bus.gpio_in_sync[i];
      end
    end
  end

  assign rise = valid & qual & cand & ~filt_q;
  assign fall = valid & qual & ~cand & filt_q;

  always_comb begin
    set = '0;
    for (int i = 0; i < N_GPIO; i++) begin
`ifdef GPIO_IRQ_LEVEL_EN
      if (bus.cfg_level[i])
        set[i] = valid[i] & (filt_q[i] ? bus.cfg_rise_en[i] : bus.cfg_fall_en[i]);
      else
        set[i] = (rise[i] & bus.cfg_rise_en[i]) | (fall[i] & bus.cfg_fall_en[i]);
`else
      set[i] = (rise[i] & bus.cfg_rise_en[i]) | (fall[i] & bus.cfg_fall_en[i]);
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt    <= '0;
      fill   <= '0;
      valid  <= '0;
      filt_q <= '0;
      stat_q <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < N_GPIO; i++) hist[i] <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        if (fill != FILL_MAX) fill <= fill + 1'b1;
        for (int i = 0; i < N_GPIO; i++)
          hist[i] <= {hist[i][FILT_DEPTH-2:0], bus.gpio_in_sync[i]};
      end
      valid  <= valid | qual;
      filt_q <= (qual & cand) | (~qual & filt_q);
      // Set wins over a simultaneous clear on the same pin.
      stat_q <= (stat_q & ~bus.status_clr) | set;
      irq_q  <= |(stat_q & bus.cfg_irq_en);
    end
  end

  assign bus.gpio_filt  = filt_q;
  assign bus.irq_status = stat_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_gpio_irq_filter.sv
// Vector-table bench for gpio_irq_filter; level-mode vectors are added when
// GPIO_IRQ_LEVEL_EN is defined.
module tb_gpio_irq_filter;
  typedef struct {
    logic        rst;
    logic        fen;
    logic [15:0] div;
    logic [31:0] in;
    logic [31:0] rise;
    logic [31:0] fall;
    logic [31:0] irq_en;
    logic [31:0] clr;
    logic [31:0] level;
    logic [31:0] e_filt;
    logic [31:0] e_stat;
    logic        e_irq;
  } vec_t;

  logic clk;
  logic rst;
  gpio_irq_filter_if bus ();

  gpio_irq_filter dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t        vecs[$];
  logic [64:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Current configuration captured by each added vector.
  logic        c_fen;
  logic [15:0] c_div;
  logic [31:0] c_rise, c_fall, c_irq, c_level;

  function automatic void addn(input int n, input logic r, input logic [31:0] in,
                               input logic [31:0] clr, input logic [31:0] e_filt,
                               input logic [31:0] e_stat, input logic e_irq);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.rst = r; v.fen = c_fen; v.div = c_div; v.in = in;
      v.rise = c_rise; v.fall = c_fall; v.irq_en = c_irq; v.clr = clr;
      v.level = c_level; v.e_filt = e_filt; v.e_stat = e_stat; v.e_irq = e_irq;
      vecs.push_back(v);
    end
  endfunction

  task automatic check(input int idx, input string what, input logic [31:0] got,
                       input logic [31:0] want);
    if (got !== want) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h want %h", idx, what, got, want);
    end
  endtask

  initial begin
    logic [64:0] e;
    logic [31:0] hi_irq, hi_clr, hi_rise;

    c_fen = 1'b1; c_div = 16'd0; c_rise = 32'h20; c_fall = 32'h0;
    c_irq = 32'h20; c_level = 32'h0;
    // Reset with all pins high: filter loads without raising status.
    addn(2, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 0);
    addn(3, 0, 32'hFFFF_FFFF, 0, 32'h0,         0, 0);
    addn(2, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 0);
    addn(3, 0, 32'h0,         0, 32'hFFFF_FFFF, 0, 0);
    addn(2, 0, 32'h0,         0, 32'h0,         0, 0);
    // Pin 5 rise, then W1C.
    addn(3, 0, 32'h20, 0,     32'h0,  32'h0,  0);
    addn(1, 0, 32'h20, 0,     32'h20, 32'h20, 0);
    addn(1, 0, 32'h20, 0,     32'h20, 32'h20, 1);
    addn(1, 0, 32'h20, 32'h20, 32'h20, 32'h0, 1);
    addn(1, 0, 32'h20, 0,     32'h20, 32'h0,  0);
    // Masking: status with mask off, then unmask.
    c_rise = 32'h21; c_irq = 32'h0;
    addn(3, 0, 32'h21, 0, 32'h20, 32'h0, 0);
    addn(2, 0, 32'h21, 0, 32'h21, 32'h1, 0);
    c_irq = 32'h1;
    addn(1, 0, 32'h21, 0,     32'h21, 32'h1, 1);
    addn(1, 0, 32'h21, 32'h1, 32'h21, 32'h0, 1);
    addn(1, 0, 32'h21, 0,     32'h21, 32'h0, 0);
    // Pin 7: fall event coincides with clear; set wins.
    c_rise = 32'hA1; c_fall = 32'h80;
    addn(3, 0, 32'hA1, 0,     32'h21, 32'h0,  0);
    addn(1, 0, 32'hA1, 0,     32'hA1, 32'h80, 0);
    addn(3, 0, 32'h21, 0,     32'hA1, 32'h80, 0);
    addn(1, 0, 32'h21, 32'h80, 32'h21, 32'h80, 0);
    addn(1, 0, 32'h21, 0,     32'h21, 32'h80, 0);
    addn(1, 0, 32'h21, 32'h80, 32'h21, 32'h0, 0);
    addn(1, 0, 32'h21, 0,     32'h21, 32'h0,  0);
    // Bypass: one-cycle path.
    c_fen = 1'b0;
    addn(1, 0, 32'h21, 0, 32'h21, 32'h0,  0);
    addn(1, 0, 32'h01, 0, 32'h01, 32'h0,  0);
    addn(1, 0, 32'h21, 0, 32'h21, 32'h20, 0);
    c_irq = 32'h20;
    addn(1, 0, 32'h21, 0,      32'h21, 32'h20, 1);
    addn(1, 0, 32'h21, 32'h20, 32'h21, 32'h0,  1);
    addn(1, 0, 32'h21, 0,      32'h21, 32'h0,  0);
    // Re-enable filter with cfg_div=3: 2-tick glitch ignored, 3-tick pulse passes.
    c_fen = 1'b1; c_div = 16'd3; c_rise = 32'hA3;
    addn(1, 0, 32'h21, 0, 32'h21, 32'h0, 0);
    addn(8, 0, 32'h23, 0, 32'h21, 32'h0, 0);
    addn(6, 0, 32'h21, 0, 32'h21, 32'h0, 0);
    addn(9, 0, 32'h23, 0, 32'h21, 32'h0, 0);
    addn(3, 0, 32'h23, 0, 32'h23, 32'h2, 0);
    addn(1, 0, 32'h21, 0, 32'h23, 32'h2, 0);
    // Reset mid-filter: no spurious edge after re-arm.
    c_div = 16'd0;
    addn(2, 1, 32'h21, 0, 32'h0,  32'h0, 0);
    addn(3, 0, 32'h23, 0, 32'h0,  32'h0, 0);
    addn(2, 0, 32'h23, 0, 32'h23, 32'h0, 0);
`ifdef GPIO_IRQ_LEVEL_EN
    // Pin 2 active-high level: clear cannot stick while high.
    c_level = 32'h4; c_rise = 32'hA7;
    addn(3, 0, 32'h27, 0,     32'h23, 32'h0, 0);
    addn(1, 0, 32'h27, 0,     32'h27, 32'h0, 0);
    addn(1, 0, 32'h27, 0,     32'h27, 32'h4, 0);
    addn(1, 0, 32'h27, 32'h4, 32'h27, 32'h4, 0);
    addn(1, 0, 32'h27, 0,     32'h27, 32'h4, 0);
    addn(1, 0, 32'h23, 32'h4, 32'h27, 32'h4, 0);
    addn(2, 0, 32'h23, 0,     32'h27, 32'h4, 0);
    addn(1, 0, 32'h23, 0,     32'h23, 32'h4, 0);
    addn(1, 0, 32'h23, 32'h4, 32'h23, 32'h0, 0);
    addn(1, 0, 32'h23, 0,     32'h23, 32'h0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      // Upper pins never see activity after the early vectors, so their
      // mask/clear (and later rise enable) bits are free to randomise.
      hi_irq  = {$urandom_range(0, 32'h00FF_FFFF), 8'h00};
      hi_clr  = {$urandom_range(0, 32'h00FF_FFFF), 8'h00};
      hi_rise = (i >= 11) ? {$urandom_range(0, 32'h00FF_FFFF), 8'h00} : 32'h0;
      rst                = vecs[i].rst;
      bus.gpio_in_sync   = vecs[i].in;
      bus.cfg_filter_en  = vecs[i].fen;
      bus.cfg_div        = vecs[i].div;
      bus.cfg_rise_en    = vecs[i].rise | hi_rise;
      bus.cfg_fall_en    = vecs[i].fall;
      bus.cfg_irq_en     = vecs[i].irq_en | hi_irq;
      bus.status_clr     = vecs[i].clr | hi_clr;
`ifdef GPIO_IRQ_LEVEL_EN
      bus.cfg_level      = vecs[i].level;
`endif
      exp_q.push_back({vecs[i].e_filt, vecs[i].e_stat, vecs[i].e_irq});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_vec++;
      check(i, "gpio_filt",  bus.gpio_filt,         e[64:33]);
      check(i, "irq_status", bus.irq_status,        e[32:1]);
      check(i, "irq",        {31'b0, bus.irq},      {31'b0, e[0]});
    end

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: got %0d leftover entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
